matrix_result_serializer: RTL and testbench



---
 rtl/matrix_result_serializer.sv | 154 +++++++++++++++
 tb/tb_matrix_result_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer
//
// Output stage of the 3x3 matrix multiplier. On start it snapshots the
// flattened result matrix into a shadow register, then streams every
// element as bytes (element 0 first, each element zero-extended to a whole
// number of bytes and sent MSB byte first) over a valid/ready handshake.
// When the last byte is accepted it raises a sticky done flag, which stays
// high until the next start.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   start      output-phase enable; only honoured in IDLE and DONE
//   c_flat     flattened results, element k at [k*ELEM_W +: ELEM_W]
//   out_ready  consumer accepts data_out when high
//   data_out   current stream byte (8'h00 when not streaming)
//   out_valid  data_out holds a valid byte
//   done       whole stream accepted (sticky)
//
// Optional feature, enabled by defining SERIALIZER_CHECKSUM_EN:
//   one extra byte, the XOR of all data bytes, follows the last data byte.

module matrix_result_serializer #(
    parameter int unsigned N_ELEM = 9,
    parameter int unsigned ELEM_W = 18  // legal range 9..24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_ELEM*ELEM_W-1:0] c_flat,
    input  logic                     out_ready,
    output logic [7:0]               data_out,
    output logic                     out_valid,
    output logic                     done
);

    localparam int unsigned BYTES_PER_ELEM = (ELEM_W + 7) / 8;
    localparam int unsigned TotalBytes     = N_ELEM * BYTES_PER_ELEM;
    localparam int unsigned CntW           = $clog2(TotalBytes + 1);
    localparam int unsigned IdxW           = $clog2(TotalBytes);
`ifdef SERIALIZER_CHECKSUM_EN
    localparam int unsigned StreamLen      = TotalBytes + 1;
`else
    localparam int unsigned StreamLen      = TotalBytes;
`endif
    localparam logic [CntW-1:0] LastIdx    = CntW'(StreamLen - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [N_ELEM*ELEM_W-1:0] shadow_q, shadow_d;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    logic [7:0] stream_bytes [TotalBytes];
    logic [7:0] cur_byte;
    logic       load;

    // Flatten the shadow register into the byte stream order: element-major,
    // MSB byte of each zero-extended element first.
    for (genvar k = 0; k < N_ELEM; k++) begin : g_elem
        logic [8*BYTES_PER_ELEM-1:0] ext;
        assign ext = (8*BYTES_PER_ELEM)'(shadow_q[k*ELEM_W +: ELEM_W]);
        for (genvar b = 0; b < BYTES_PER_ELEM; b++) begin : g_byte
            assign stream_bytes[k*BYTES_PER_ELEM + b] = ext[(BYTES_PER_ELEM-1-b)*8 +: 8];
        end
    end

    always_comb begin
        cur_byte = stream_bytes[cnt_q[IdxW-1:0]];
`ifdef SERIALIZER_CHECKSUM_EN
        // Index one past the data bytes selects the running checksum.
        if (cnt_q == CntW'(TotalBytes)) begin
            cur_byte = csum_q;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
`ifdef SERIALIZER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        data_out  = 8'h00;
        out_valid = 1'b0;
        done      = 1'b0;
        load      = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = start;
            end
            StSend: begin
                out_valid = 1'b1;
                data_out  = cur_byte;
                if (out_ready) begin
`ifdef SERIALIZER_CHECKSUM_EN
                    csum_d = csum_q ^ cur_byte;
`endif
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                done = 1'b1;
                load = start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Entry to SEND is identical from IDLE and DONE.
        if (load) begin
            shadow_d = c_flat;
            cnt_d    = '0;
            state_d  = StSend;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_d   = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Self-checking bench for matrix_result_serializer.
// Expected byte streams come from a queue model built directly from the
// element values with shifts and masks.

module tb_matrix_result_serializer;

    localparam int unsigned NElem    = 9;
    localparam int unsigned ElemW    = 18;
    localparam int unsigned Bpe      = 3;
    localparam int unsigned MaxCyc   = 400;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [NElem*ElemW-1:0] c_flat;
    logic                   out_ready;
    logic [7:0]             data_out;
    logic                   out_valid;
    logic                   done;

    int          checks   = 0;
    int          failures = 0;
    int unsigned elems [NElem];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    matrix_result_serializer #(
        .N_ELEM (NElem),
        .ELEM_W (ElemW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .c_flat    (c_flat),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive c_flat from elems[] and build the expected byte stream.
    task automatic load_model();
        logic [7:0] csum;
        exp_q.delete();
        for (int k = 0; k < NElem; k++) begin
            c_flat[k*ElemW +: ElemW] = ElemW'(elems[k]);
            for (int b = Bpe - 1; b >= 0; b--) begin
                exp_q.push_back(8'((elems[k] >> (8 * b)) & 32'hFF));
            end
        end
`ifdef SERIALIZER_CHECKSUM_EN
        csum = 8'h00;
        foreach (exp_q[i]) csum = csum ^ exp_q[i];
        exp_q.push_back(csum);
`else
        csum = 8'h00;
`endif
    endtask

    // mode: 0 = always ready, 1 = ready pattern 1-0-0-1, 2 = random ready.
    // disturb: at byte 5 overwrite c_flat with all-ones and pulse start.
    // abort_at: >= 0 asserts reset once that many bytes have been accepted.
    task automatic run_stream(input int mode, input bit disturb, input int abort_at);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        load_model();
        @(negedge clk);
        check_eq("pre_start_valid", 32'(out_valid), 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (idx < exp_q.size() && cyc < MaxCyc) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            @(negedge clk);
            check_eq("valid", 32'(out_valid), 1);
            check_eq($sformatf("byte%0d", idx), 32'(data_out), 32'(exp_q[idx]));
            check_eq("done_low", 32'(done), 0);
            if (disturb && idx == 5) begin
                c_flat = '1;
                start  = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            if (rdy) idx++;
            cyc++;
            if (abort_at >= 0 && idx == abort_at) break;
        end

        if (abort_at >= 0) begin
            rst       = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check_eq("rst_valid", 32'(out_valid), 0);
                check_eq("rst_done", 32'(done), 0);
                check_eq("rst_data", 32'(data_out), 0);
            end
            return;
        end

        if (idx < exp_q.size()) check_eq("stream_timeout", 32'(idx), 32'(exp_q.size()));

        for (int i = 0; i < 3; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("end_valid", 32'(out_valid), 0);
            check_eq("end_done", 32'(done), 1);
            check_eq("end_data", 32'(data_out), 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        c_flat    = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("reset_data", 32'(data_out), 0);
            check_eq("reset_valid", 32'(out_valid), 0);
            check_eq("reset_done", 32'(done), 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("idle_data", 32'(data_out), 0);
        check_eq("idle_valid", 32'(out_valid), 0);
        check_eq("idle_done", 32'(done), 0);

        // Ordering, then backpressure, then capture isolation.
        for (int k = 0; k < NElem; k++) elems[k] = 32'h12340 + k;
        run_stream(0, 1'b0, -1);
        run_stream(1, 1'b0, -1);
        run_stream(0, 1'b1, -1);

        // Random data with random backpressure, restarting from DONE.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NElem; k++) elems[k] = $urandom_range(0, (1 << ElemW) - 1);
            run_stream(2, 1'b0, -1);
        end

        // Mid-stream reset, then a fresh stream from IDLE.
        for (int k = 0; k < NElem; k++) elems[k] = $urandom_range(0, (1 << ElemW) - 1);
        run_stream(2, 1'b0, 10);
        for (int k = 0; k < NElem; k++) elems[k] = $urandom_range(0, (1 << ElemW) - 1);
        run_stream(0, 1'b0, -1);

        // All-ones elements: {03,FF,FF} x 9 (checksum byte 03 when enabled).
        for (int k = 0; k < NElem; k++) elems[k] = 32'h3FFFF;
        run_stream(1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
